rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Write-side companion of the instruction ROM: fills the ROM image at run time over a byte stream.
//  Consumes bytes from a UART-style receiver (valid/ready), parses a length header and assembles
//  little-endian 32-bit words. Issues one word write per word to the memory write port starting at BASE_ADDR.
//  Sits between the debug/boot UART receiver and the ROM array's write port. Only this loader writes the ROM image.
// PARAMETERS
//  BASE_ADDR  ROM_BASE_ADDR (typepkg)  byte address of first word written
//  MAX_WORDS  (ROM_END_ADDR-ROM_BASE_ADDR)>>2  capacity in words; larger header count = error
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  start     in   1   pulse: abort any load, clear counters, re-arm for a new header
//  rx_data   in   8   received byte
//  rx_valid  in   1   rx_data valid
//  rx_ready  out  1   loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//  wr_valid  out  1   write request to memory
//  wr_ready  in   1   memory accepts write (transfer = wr_valid & wr_ready)
//  wr_addr   out  32  byte address, word-aligned (bits[1:0]=0)
//  wr_data   out  32  word to write
//  busy      out  1   load in progress (HDR after >=1 byte, DATA, WRITE)
//  done      out  1   sticky: all N words written
//  err       out  1   sticky: header count > MAX_WORDS
// BEHAVIOUR
//  States: HDR (collect 4-byte LE count N), DATA (collect 4-byte LE word), WRITE, DONE, ERR.
//  Reset: state=HDR, byte_cnt=0, idx=0, N=0, assembly reg=0; wr_valid=0, wr_addr=BASE_ADDR, wr_data=0,
//   busy=0, done=0, err=0. rx_ready forced 0 while rst_n low.
//  rx_ready = (state==HDR|DATA) & !start; 0 in WRITE/DONE/ERR.
//  Byte assembly: k-th accepted byte (k=0..3) -> bits[8k+7:8k]; byte_cnt 2 bits, wraps 3->0 on 4th byte.
//  HDR: on 4th byte -> N latched (32 bits, unsigned compare).
//   N==0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
//  DATA: on 4th byte, next cycle state=WRITE, wr_valid=1.
//   wr_data=assembled word, wr_addr=BASE_ADDR+4*idx (32-bit, no wrap check beyond MAX_WORDS bound).
//  WRITE: wr_valid, wr_addr, wr_data held stable until wr_ready. On transfer: wr_valid=0 next cycle, idx++.
//   idx==N -> DONE, else -> DATA. wr_ready while wr_valid=0 ignored.
//  Latency: 4th data byte accepted at edge t -> wr_valid high from t+1; min 1 cycle in WRITE.
//  DONE: done=1, busy=0, no bytes accepted, no writes. ERR: err=1, busy=0, nothing written, no bytes accepted.
//  start (any state, including mid-word or WRITE): next cycle state=HDR.
//   Clears byte_cnt, idx, N, done, err, wr_valid. start has priority over rx/wr transfers in that cycle:
//   rx_ready=0, and a wr_ready in that cycle does not count as a transfer.
//  rx_valid gaps between bytes: no timeout, partial word/header held indefinitely.
//  Async reset mid-load: immediate return to reset values; partially written image is not rolled back.
// TESTING
//  1 Reset: rst_n low 3 cycles -> all outputs at reset values, rx_ready=0. Release -> rx_ready=1 in HDR.
//  2 Load 2 words: bytes 02 00 00 00 78 56 34 12 EF BE AD DE, wr_ready=1.
//    -> writes (BASE,0x12345678) then (BASE+4,0xDEADBEEF), then done=1, busy=0, rx_ready=0.
//  3 Backpressure: same stream, wr_ready low 3 cycles on first write.
//    -> wr_valid/addr/data stable, rx_ready=0 throughout, exactly 2 write transfers.
//  4 Header 00 00 00 00 -> done=1 the cycle after the 4th byte, wr_valid never asserted.
//  5 Header count MAX_WORDS+1 -> err=1, no writes, rx_ready=0. Then start pulse
//    -> err=0, HDR, and a following 1-word load succeeds.
//  6 Abort: start after 2 data bytes of word 0 -> byte_cnt cleared.
//    Fresh header 01 00 00 00 + AA BB CC DD -> single write (BASE,0xDDCCBBAA). rst_n mid-word behaves the same.

Source files
------------

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte stream in and word write port out of the ROM loader.
interface rom_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic wr_valid;
  logic wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  modport master (
    input rx_data, rx_valid, wr_ready,
    output rx_ready, wr_valid, wr_addr, wr_data
  );
  modport slave (
    output rx_data, rx_valid, wr_ready,
    input rx_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: parses a LE word-count header from a byte stream and writes LE words to the ROM from BASE_ADDR.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  rom_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [1:0] byte_cnt;
  logic [31:0] idx;
  logic [31:0] n;
  logic [23:0] asm_q;
  logic rx_fire;
  logic last;
  logic [31:0] word;
  // bytes shift in from the top, so after three bytes asm_q holds {b2,b1,b0}
  assign word = {bus.rx_data, asm_q};
  assign last = byte_cnt == 2'd3;
  assign bus.rx_ready = rst_n & ~start & (state == HDR | state == DATA);
  assign rx_fire = bus.rx_valid & bus.rx_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HDR;
      byte_cnt <= '0;
      idx <= '0;
      n <= '0;
      asm_q <= '0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr <= BASE_ADDR;
      bus.wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else if (start) begin
      state <= HDR;
      byte_cnt <= '0;
      idx <= '0;
      n <= '0;
      asm_q <= '0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr <= BASE_ADDR;
      bus.wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        HDR, DATA: if (rx_fire) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q <= word[31:8];
          busy <= 1'b1;
          if (last && state == HDR) begin
            n <= word;
            state <= word == 32'd0 ? DONE : word > MAX_WORDS ? ERR : DATA;
            busy <= word != 32'd0 && word <= MAX_WORDS;
            done <= word == 32'd0;
            err <= word > MAX_WORDS;
          end else if (last) begin
            state <= WRITE;
            bus.wr_valid <= 1'b1;
            bus.wr_data <= word;
            bus.wr_addr <= BASE_ADDR + (idx << 2);
          end
        end
        WRITE: if (bus.wr_ready) begin
          bus.wr_valid <= 1'b0;
          idx <= idx + 32'd1;
          state <= idx + 32'd1 == n ? DONE : DATA;
          busy <= idx + 32'd1 != n;
          done <= idx + 32'd1 == n;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized byte streams checked against a list-level model of the ROM image load.
module tb_rom_loader;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int MAX = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic busy, done, err;
  int vecs = 0;
  int errs = 0;
  bit auto_wr = 1;
  bit rand_wr = 0;
  logic [7:0] stream[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  bit exp_done, exp_err;
  rom_loader_if bus();
  rom_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    bus.rx_data = 0;
    bus.rx_valid = 0;
    bus.wr_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (auto_wr) bus.wr_ready = rand_wr ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  // capture write transfers and check a stalled request stays put
  initial begin
    logic pend;
    logic [63:0] prev;
    pend = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || start) pend = 0;
      else begin
        if (pend) begin
          vecs++;
          if (!bus.wr_valid || {bus.wr_addr, bus.wr_data} !== prev) begin
            errs++;
            $display("FAIL hold: got v=%0b %h, need v=1 %h", bus.wr_valid, {bus.wr_addr, bus.wr_data}, prev);
          end
        end
        if (bus.wr_valid && bus.wr_ready) got_q.push_back({bus.wr_addr, bus.wr_data});
        pend = bus.wr_valid && !bus.wr_ready;
        prev = {bus.wr_addr, bus.wr_data};
      end
    end
  end
  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
  endtask
  task automatic model();
    logic [31:0] cnt;
    logic [31:0] w;
    cnt = {stream[3], stream[2], stream[1], stream[0]};
    exp_q.delete();
    exp_err = cnt > MAX;
    exp_done = !exp_err;
    if (!exp_err)
      for (int i = 0; i < int'(cnt); i++) begin
        w = {stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]};
        exp_q.push_back({BASE + 32'(4 * i), w});
      end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1;
    while (!bus.rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      errs++;
      $display("FAIL rx_timeout: rx_ready=%0b after %0d cycles, need 1", bus.rx_ready, t);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 0;
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (!(done || err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    vecs++;
    if (t >= 200) begin
      errs++;
      $display("FAIL idle_timeout: done=%0b err=%0b, need one set", done, err);
    end
  endtask
  task automatic check_results(input string name);
    @(negedge clk);
    vecs++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL %s count: got %0d writes, need %0d", name, got_q.size(), exp_q.size());
    end else
      foreach (exp_q[i]) begin
        vecs++;
        if (got_q[i] !== exp_q[i]) begin
          errs++;
          $display("FAIL %s write%0d: got %h, need %h", name, i, got_q[i], exp_q[i]);
        end
      end
    vecs++;
    if ({done, err, busy, bus.rx_ready, bus.wr_valid} !== {exp_done, exp_err, 3'b000}) begin
      errs++;
      $display("FAIL %s status: got done/err/busy/rdy/wv=%b, need %b", name,
               {done, err, busy, bus.rx_ready, bus.wr_valid}, {exp_done, exp_err, 3'b000});
    end
  endtask
  task automatic run_load(input string name);
    got_q.delete();
    model();
    foreach (stream[i]) send_byte(stream[i]);
    wait_idle();
    check_results(name);
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({bus.rx_ready, bus.wr_valid, busy, done, err} !== 5'b0 || bus.wr_addr !== BASE || bus.wr_data !== 32'd0) begin
      errs++;
      $display("FAIL reset: got rdy/wv/busy/done/err=%b addr=%h data=%h, need 00000 %h 0",
               {bus.rx_ready, bus.wr_valid, busy, done, err}, bus.wr_addr, bus.wr_data, BASE);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    vecs++;
    if (bus.rx_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got rdy=%0b busy=%0b, need 1 0", bus.rx_ready, busy);
    end
  endtask
  task automatic test_two_words();
    rand_wr = 0;
    stream.delete();
    add_word(2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
    got_q.delete();
    model();
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    vecs++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== BASE || bus.wr_data !== 32'h1234_5678) begin
      errs++;
      $display("FAIL latency: got wv=%0b %h %h, need 1 %h 12345678", bus.wr_valid, bus.wr_addr, bus.wr_data, BASE);
    end
    for (int i = 8; i < 12; i++) send_byte(stream[i]);
    wait_idle();
    check_results("two_words");
  endtask
  task automatic test_backpressure();
    pulse_start();
    auto_wr = 0;
    @(posedge clk);
    #1 bus.wr_ready = 0;
    stream.delete();
    add_word(2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
    got_q.delete();
    model();
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (!bus.wr_valid || bus.wr_addr !== BASE || bus.wr_data !== 32'h1234_5678 || bus.rx_ready || !busy) begin
        errs++;
        $display("FAIL stall: got wv=%0b %h %h rdy=%0b busy=%0b, need 1 %h 12345678 0 1",
                 bus.wr_valid, bus.wr_addr, bus.wr_data, bus.rx_ready, busy, BASE);
      end
    end
    @(posedge clk);
    #1 bus.wr_ready = 1;
    for (int i = 8; i < 12; i++) send_byte(stream[i]);
    wait_idle();
    check_results("backpressure");
    auto_wr = 1;
  endtask
  task automatic test_zero();
    pulse_start();
    stream.delete();
    add_word(0);
    got_q.delete();
    model();
    foreach (stream[i]) send_byte(stream[i]);
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL zero_done: got done=%0b the cycle after the header, need 1", done);
    end
    repeat (3) @(negedge clk);
    check_results("zero");
  endtask
  task automatic test_err();
    pulse_start();
    stream.delete();
    add_word(MAX + 1);
    run_load("over");
    pulse_start();
    @(negedge clk);
    vecs++;
    if ({err, done, busy, bus.rx_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL err_clear: got err/done/busy/rdy=%b, need 0001", {err, done, busy, bus.rx_ready});
    end
    stream.delete();
    add_word(1);
    add_word($urandom);
    run_load("after_err");
  endtask
  task automatic partial();
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL partial_busy: got busy=%0b, need 1", busy);
    end
  endtask
  task automatic test_abort();
    pulse_start();
    partial();
    pulse_start();
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort: got busy=%0b rdy=%0b, need 0 1", busy, bus.rx_ready);
    end
    stream.delete();
    add_word(1);
    add_word(32'hDDCC_BBAA);
    run_load("abort_start");
    pulse_start();
    partial();
    pulse_reset();
    stream.delete();
    add_word(1);
    add_word(32'hDDCC_BBAA);
    run_load("abort_reset");
  endtask
  task automatic test_random();
    rand_wr = 1;
    for (int k = 0; k < 6; k++) begin
      pulse_start();
      stream.delete();
      if (k == 5) add_word($urandom_range(MAX + 1, 1000));
      else begin
        int n;
        n = $urandom_range(1, MAX);
        add_word(n);
        for (int i = 0; i < n; i++) add_word($urandom);
      end
      run_load("random");
    end
    rand_wr = 0;
  endtask
  initial begin
    test_reset();
    test_two_words();
    test_backpressure();
    test_zero();
    test_err();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
